// File: rtl/dram_cbr_refresh.sv
// CAS-before-RAS refresh scheduler and strobe multiplexer for the fast-RAM DRAM array.
// Acc strobes pass through while idle; refresh cycles run from registered strobes.
module dram_cbr_refresh #(
    parameter int REFRESH_INTERVAL = 108,
    parameter int MAX_PENDING      = 3,
    parameter int RAS_CYCLES       = 2
) (
    input  logic       CLKCPU,
    input  logic       RESETn,
    input  logic       cpu_nas,
    input  logic       acc_nras,
    input  logic       acc_nlcas,
    input  logic       acc_nucas,
    output logic       dram_nras,
    output logic       dram_nlcas,
    output logic       dram_nucas,
    output logic       refresh_hold,
    output logic [1:0] refresh_pending
);

    localparam logic [6:0]     RELOAD   = 7'(REFRESH_INTERVAL - 1);
    localparam logic [1:0]     PEND_MAX = 2'(MAX_PENDING);
    localparam int             RCW      = (RAS_CYCLES > 1) ? $clog2(RAS_CYCLES) : 1;
    localparam logic [RCW-1:0] RAS_LAST = RCW'(RAS_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, CAS, RAS, PRE} state_e;

    state_e         state_q, state_d;
    logic [6:0]     interval_q, interval_d;
    logic [1:0]     pending_q, pending_d;
    logic [RCW-1:0] ras_cnt_q, ras_cnt_d;
    logic           nras_q, nras_d;
    logic           ncas_q, ncas_d;
    logic           hold_q, hold_d;
    logic           strobes_idle;
    logic           expire;
    logic           start;

    assign strobes_idle = acc_nras & acc_nlcas & acc_nucas;
    assign expire       = (interval_q == 7'd0);
    // A saturated debt overrides the wait for a free CPU bus cycle.
    assign start        = (state_q == IDLE) && strobes_idle && (pending_q != 2'd0)
                          && (cpu_nas || (pending_q == PEND_MAX));

    always_ff @(posedge CLKCPU or negedge RESETn) begin
        if (!RESETn) begin
            state_q   <= IDLE;
            ras_cnt_q <= '0;
            nras_q    <= 1'b1;
            ncas_q    <= 1'b1;
            hold_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ras_cnt_q <= ras_cnt_d;
            nras_q    <= nras_d;
            ncas_q    <= ncas_d;
            hold_q    <= hold_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ras_cnt_d = ras_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CAS;
                end
            end
            CAS: begin
                state_d   = RAS;
                ras_cnt_d = '0;
            end
            RAS: begin
                if (ras_cnt_q == RAS_LAST) begin
                    state_d = PRE;
                end else begin
                    ras_cnt_d = ras_cnt_q + 1'b1;
                end
            end
            PRE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Strobes and hold are decoded from the next state so they leave a flop cleanly.
    always_comb begin
        nras_d = 1'b1;
        ncas_d = 1'b1;
        hold_d = 1'b0;
        unique case (state_d)
            IDLE: begin
                hold_d = 1'b0;
            end
            CAS: begin
                ncas_d = 1'b0;
                hold_d = 1'b1;
            end
            RAS: begin
                nras_d = 1'b0;
                ncas_d = 1'b0;
                hold_d = 1'b1;
            end
            PRE: begin
                hold_d = 1'b1;
            end
            default: begin
                hold_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        interval_d = expire ? RELOAD : (interval_q - 7'd1);
        pending_d  = pending_q;
        if (expire && !start && (pending_q != PEND_MAX)) begin
            pending_d = pending_q + 2'd1;
        end else if (start && !expire) begin
            pending_d = pending_q - 2'd1;
        end
    end

    always_ff @(posedge CLKCPU or negedge RESETn) begin
        if (!RESETn) begin
            interval_q <= RELOAD;
            pending_q  <= 2'd0;
        end else begin
            interval_q <= interval_d;
            pending_q  <= pending_d;
        end
    end

    // Strobes are forced inactive for the whole time reset is held.
    assign dram_nras       = !RESETn || ((state_q == IDLE) ? acc_nras  : nras_q);
    assign dram_nlcas      = !RESETn || ((state_q == IDLE) ? acc_nlcas : ncas_q);
    assign dram_nucas      = !RESETn || ((state_q == IDLE) ? acc_nucas : ncas_q);
    assign refresh_hold    = hold_q;
    assign refresh_pending = pending_q;

endmodule

// File: tb/tb_dram_cbr_refresh.sv
// Self-checking bench for dram_cbr_refresh: refresh timeline, passthrough table,
// saturation/forced refresh, mid-refresh reset and counter/start coincidence.
module tb_dram_cbr_refresh;

    logic       CLKCPU = 1'b0;
    logic       RESETn;
    logic       cpu_nas;
    logic       acc_nras;
    logic       acc_nlcas;
    logic       acc_nucas;
    logic       dram_nras;
    logic       dram_nlcas;
    logic       dram_nucas;
    logic       refresh_hold;
    logic [1:0] refresh_pending;

    int testsRun    = 0;
    int testsFailed = 0;
    int cyc;

    typedef struct {
        string      name;
        logic [5:0] exp;
    } sb_t;

    typedef struct {
        logic       nas;
        logic       nras;
        logic       nlcas;
        logic       nucas;
        logic [5:0] exp;
    } vec_t;

    sb_t  sbq[$];
    vec_t vecs[8];

    dram_cbr_refresh dut (
        .CLKCPU          (CLKCPU),
        .RESETn          (RESETn),
        .cpu_nas         (cpu_nas),
        .acc_nras        (acc_nras),
        .acc_nlcas       (acc_nlcas),
        .acc_nucas       (acc_nucas),
        .dram_nras       (dram_nras),
        .dram_nlcas      (dram_nlcas),
        .dram_nucas      (dram_nucas),
        .refresh_hold    (refresh_hold),
        .refresh_pending (refresh_pending)
    );

    always #5 CLKCPU = ~CLKCPU;

    // Rising edges since reset release; checks at negedge see cyc == edge number.
    always @(posedge CLKCPU or negedge RESETn) begin
        if (!RESETn) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    function automatic logic [5:0] pack(input logic ras, input logic lcas, input logic ucas,
                                        input logic hold, input logic [1:0] pend);
        return {ras, lcas, ucas, hold, pend};
    endfunction

    // Expected outputs n clocks after reset release with the bus idle and cpu_nas high.
    function automatic logic [5:0] expTimeline(input int n);
        logic cas;
        logic ras;
        logic hold;
        logic [1:0] pend;
        cas  = !(n >= 109 && n <= 111);
        ras  = !(n == 110 || n == 111);
        hold = (n >= 109 && n <= 112);
        pend = (n == 108) ? 2'd1 : 2'd0;
        return pack(ras, cas, cas, hold, pend);
    endfunction

    task automatic applyStimulus(input logic nas, input logic nras, input logic nlcas,
                                 input logic nucas);
        cpu_nas   = nas;
        acc_nras  = nras;
        acc_nlcas = nlcas;
        acc_nucas = nucas;
    endtask

    task automatic expectOut(input string name, input logic [5:0] exp);
        sb_t e;
        e.name = name;
        e.exp  = exp;
        sbq.push_back(e);
    endtask

    task automatic checkOutput();
        sb_t        e;
        logic [5:0] act;
        e   = sbq.pop_front();
        act = {dram_nras, dram_nlcas, dram_nucas, refresh_hold, refresh_pending};
        testsRun++;
        if (act !== e.exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: nras/nlcas/nucas/hold/pending actual=%b expected=%b (t=%0t)",
                     e.name, act, e.exp, $time);
        end
    endtask

    task automatic waitCyc(input int n);
        int guard = 0;
        while (cyc < n && guard < 2000) begin
            @(negedge CLKCPU);
            guard++;
        end
        if (cyc != n) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL wait_c%0d: cycle actual=%0d expected=%0d", n, cyc, n);
        end
    endtask

    task automatic checkAt(input int n, input string name, input logic [5:0] exp);
        waitCyc(n);
        expectOut(name, exp);
        checkOutput();
    endtask

    task automatic doReset(input string name);
        RESETn = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        repeat (2) @(negedge CLKCPU);
        expectOut(name, pack(1'b1, 1'b1, 1'b1, 1'b0, 2'd0));
        checkOutput();
        RESETn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time actual=%0t expected below 200000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b1, pack(1'b1, 1'b0, 1'b1, 1'b0, 2'd0)};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b1, pack(1'b1, 1'b1, 1'b1, 1'b0, 2'd0)};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b1, pack(1'b1, 1'b0, 1'b1, 1'b0, 2'd0)};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, pack(1'b1, 1'b1, 1'b0, 1'b0, 2'd0)};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, pack(1'b0, 1'b0, 1'b0, 1'b0, 2'd0)};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b1, pack(1'b0, 1'b1, 1'b1, 1'b0, 2'd0)};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, pack(1'b1, 1'b0, 1'b0, 1'b0, 2'd0)};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b1, pack(1'b1, 1'b1, 1'b1, 1'b0, 2'd0)};

        // First refresh after reset, then IDLE passthrough table.
        doReset("s1_reset");
        for (int n = 1; n <= 116; n++) begin
            checkAt(n, $sformatf("s1_c%0d", n), expTimeline(n));
        end
        for (int i = 0; i < 8; i++) begin
            waitCyc(117 + i);
            applyStimulus(vecs[i].nas, vecs[i].nras, vecs[i].nlcas, vecs[i].nucas);
            #1;
            expectOut($sformatf("pass_v%0d", i), vecs[i].exp);
            checkOutput();
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);

        // Acc strobes ignored during refresh, then reset pulsed inside RAS.
        doReset("s2_reset");
        waitCyc(109);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        expectOut("s2_cas_ignores_acc", pack(1'b1, 1'b0, 1'b0, 1'b1, 2'd0));
        checkOutput();
        checkAt(110, "s2_ras", pack(1'b0, 1'b0, 1'b0, 1'b1, 2'd0));
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        #2;
        RESETn = 1'b0;
        #1;
        expectOut("s2_async_reset", pack(1'b1, 1'b1, 1'b1, 1'b0, 2'd0));
        checkOutput();
        @(negedge CLKCPU);
        RESETn = 1'b1;
        for (int n = 1; n <= 116; n++) begin
            checkAt(n, $sformatf("s2_c%0d", n), expTimeline(n));
        end

        // Counter expiry on the same edge as a refresh start.
        doReset("s3_reset");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        checkAt(108, "s3_pend1", pack(1'b0, 1'b1, 1'b1, 1'b0, 2'd1));
        checkAt(215, "s3_blocked", pack(1'b0, 1'b1, 1'b1, 1'b0, 2'd1));
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        checkAt(216, "s3_cas_coincide", pack(1'b1, 1'b0, 1'b0, 1'b1, 2'd1));
        checkAt(217, "s3_ras", pack(1'b0, 1'b0, 1'b0, 1'b1, 2'd1));
        checkAt(219, "s3_pre", pack(1'b1, 1'b1, 1'b1, 1'b1, 2'd1));
        checkAt(220, "s3_idle", pack(1'b1, 1'b1, 1'b1, 1'b0, 2'd1));
        checkAt(221, "s3_cas2", pack(1'b1, 1'b0, 1'b0, 1'b1, 2'd0));
        checkAt(224, "s3_pre2", pack(1'b1, 1'b1, 1'b1, 1'b1, 2'd0));
        checkAt(225, "s3_done", pack(1'b1, 1'b1, 1'b1, 1'b0, 2'd0));

        // Saturation, forced refresh with cpu_nas low, acc ignored outside IDLE.
        doReset("s4_reset");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        checkAt(107, "s4_pend0", pack(1'b0, 1'b1, 1'b1, 1'b0, 2'd0));
        checkAt(108, "s4_pend1", pack(1'b0, 1'b1, 1'b1, 1'b0, 2'd1));
        checkAt(216, "s4_pend2", pack(1'b0, 1'b1, 1'b1, 1'b0, 2'd2));
        checkAt(324, "s4_pend3", pack(1'b0, 1'b1, 1'b1, 1'b0, 2'd3));
        checkAt(400, "s4_sat", pack(1'b0, 1'b1, 1'b1, 1'b0, 2'd3));
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        checkAt(401, "s4_forced_cas", pack(1'b1, 1'b0, 1'b0, 1'b1, 2'd2));
        checkAt(402, "s4_ras", pack(1'b0, 1'b0, 1'b0, 1'b1, 2'd2));
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        checkAt(403, "s4_ras2", pack(1'b0, 1'b0, 1'b0, 1'b1, 2'd2));
        checkAt(404, "s4_pre_ignores_acc", pack(1'b1, 1'b1, 1'b1, 1'b1, 2'd2));
        checkAt(405, "s4_idle_pass", pack(1'b0, 1'b1, 1'b1, 1'b0, 2'd2));
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        for (int n = 406; n <= 415; n++) begin
            checkAt(n, $sformatf("s4_wait_c%0d", n), pack(1'b1, 1'b1, 1'b1, 1'b0, 2'd2));
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        checkAt(416, "s4_cas", pack(1'b1, 1'b0, 1'b0, 1'b1, 2'd1));
        checkAt(420, "s4_idle", pack(1'b1, 1'b1, 1'b1, 1'b0, 2'd1));
        checkAt(421, "s4_cas2", pack(1'b1, 1'b0, 1'b0, 1'b1, 2'd0));
        checkAt(425, "s4_done", pack(1'b1, 1'b1, 1'b1, 1'b0, 2'd0));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
